// File: rtl/imem_arb_pkg.sv
// Shared definitions for the program-memory port arbiter.
// Holds the default bus widths, the grant-owner encoding and the
// pending-read state encoding.
package imem_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 11;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned STARVE_MAX_DEF = 8;

    // Winner of the current cycle's arbitration
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DBG   = 2'd2
    } owner_e;

    // Access accepted in the previous cycle (1-deep pending register)
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_RD = 2'd1,
        DBG_RD   = 2'd2,
        DBG_WR   = 2'd3
    } state_e;

endpackage : imem_arb_pkg

// File: rtl/imem_arb_starve_cnt.sv
// Saturating count of consecutive cycles fetch lost to debug.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   i_inc       - fetch was eligible but debug won this cycle
//   i_clr       - fetch granted, not requesting, or halted
//   o_at_max    - count has reached STARVE_MAX
module imem_arb_starve_cnt #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] r_cnt;

    assign o_at_max = (r_cnt == CNT_W'(STARVE_MAX));

    // Clear wins over increment; increment stops at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : imem_arb_starve_cnt

// File: rtl/imem_port_arbiter.sv
// Shares the single program-memory port between CPU fetch (read-only)
// and the debug unit (read/write). Debug has priority; fetch is forced
// a grant after STARVE_MAX consecutive losses. Reads return one cycle
// after acceptance with a per-requester valid strobe.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   i_dbg_halt                 - CPU halted, fetch ineligible
//   i_fetch_* / o_fetch_*      - fetch request, grant, read return
//   i_dbg_* / o_dbg_*          - debug request, grant, read return
//   o_mem_* / i_mem_dout       - memory address, data-in, write, clock gate, data-out
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_dbg_halt,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_gnt,
    output logic [DATA_W-1:0] o_fetch_rdata,
    output logic              o_fetch_rvalid,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_dbg_rvalid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    output logic              o_mem_wr,
    output logic              o_mem_hold,
    input  logic [DATA_W-1:0] i_mem_dout
);

    state_e            r_state;
    state_e            w_state_nxt;
    owner_e            w_owner;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic              w_fetch_elig;
    logic              w_at_max;

    assign w_fetch_elig = i_fetch_req && !i_dbg_halt;

    imem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_fetch_elig && (w_owner == OWN_DBG)),
        .i_clr    (!w_fetch_elig || (w_owner == OWN_FETCH)),
        .o_at_max (w_at_max)
    );

    // Pending-read owner; dropped by reset so no strobe follows release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Last driven address/data, held on idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_mem_addr <= w_addr;
            r_mem_din  <= w_din;
        end
    end

    // Arbitration, memory drive and next pending state
    always_comb begin
        w_owner     = OWN_NONE;
        w_state_nxt = IDLE;
        w_addr      = r_mem_addr;
        w_din       = r_mem_din;
        o_fetch_gnt = 1'b0;
        o_dbg_gnt   = 1'b0;
        o_mem_wr    = 1'b0;
        o_mem_hold  = 1'b1;

        // Grants are combinational, so mask them while reset is asserted
        if (rst_n) begin
            if (w_fetch_elig && w_at_max) begin
                w_owner = OWN_FETCH;
            end else if (i_dbg_req) begin
                w_owner = OWN_DBG;
            end else if (w_fetch_elig) begin
                w_owner = OWN_FETCH;
            end
        end

        case (w_owner)
            OWN_FETCH: begin
                o_fetch_gnt = 1'b1;
                o_mem_hold  = 1'b0;
                w_addr      = i_fetch_addr;
                w_din       = i_dbg_wdata;
                w_state_nxt = FETCH_RD;
            end
            OWN_DBG: begin
                o_dbg_gnt   = 1'b1;
                o_mem_hold  = 1'b0;
                o_mem_wr    = i_dbg_we;
                w_addr      = i_dbg_addr;
                w_din       = i_dbg_wdata;
                w_state_nxt = i_dbg_we ? DBG_WR : DBG_RD;
            end
            default: ;
        endcase
    end

    assign o_mem_addr     = w_addr;
    assign o_mem_din      = w_din;
    assign o_fetch_rvalid = (r_state == FETCH_RD);
    assign o_dbg_rvalid   = (r_state == DBG_RD);
    assign o_fetch_rdata  = i_mem_dout;
    assign o_dbg_rdata    = i_mem_dout;

endmodule : imem_port_arbiter

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a synchronous-read memory model.
module tb_imem_port_arbiter;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic          dbg_halt;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic [DW-1:0] fetch_rdata;
    logic          fetch_rvalid;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_wr;
    logic          mem_hold;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] mem [0:2047];

    int n_pass  = 0;
    int n_total = 0;

    imem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_dbg_halt     (dbg_halt),
        .i_fetch_req    (fetch_req),
        .i_fetch_addr   (fetch_addr),
        .o_fetch_gnt    (fetch_gnt),
        .o_fetch_rdata  (fetch_rdata),
        .o_fetch_rvalid (fetch_rvalid),
        .i_dbg_req      (dbg_req),
        .i_dbg_we       (dbg_we),
        .i_dbg_addr     (dbg_addr),
        .i_dbg_wdata    (dbg_wdata),
        .o_dbg_gnt      (dbg_gnt),
        .o_dbg_rdata    (dbg_rdata),
        .o_dbg_rvalid   (dbg_rvalid),
        .o_mem_addr     (mem_addr),
        .o_mem_din      (mem_din),
        .o_mem_wr       (mem_wr),
        .o_mem_hold     (mem_hold),
        .i_mem_dout     (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: write or registered read when the clock is not gated
    always @(posedge clk) begin
        if (!mem_hold) begin
            if (mem_wr) mem[mem_addr] <= mem_din;
            else        mem_dout      <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic drive(input logic h, input logic fr, input logic [AW-1:0] fa,
                         input logic dr, input logic we, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd);
        @(negedge clk);
        dbg_halt   = h;
        fetch_req  = fr;
        fetch_addr = fa;
        dbg_req    = dr;
        dbg_we     = we;
        dbg_addr   = da;
        dbg_wdata  = wd;
        #1;
    endtask

    typedef struct {
        logic          halt;
        logic          freq;
        logic [AW-1:0] faddr;
        logic          dreq;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwdata;
        logic          e_fgnt;
        logic          e_dgnt;
        logic          e_hold;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic          e_frv;
        logic          e_drv;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs [14];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[11'h001] = 32'h1111_1111;
        mem[11'h002] = 32'h2222_2222;
        mem[11'h003] = 32'h3333_3333;
        mem[11'h005] = 32'hDEAD_BEEF;
        mem[11'h010] = 32'hCAFE_F00D;
        mem_dout = '0;

        //          halt fr faddr   dr we daddr   wdata          fg dg hd wr addr    din            frv drv rdata
        vecs[0]  = '{0, 0, 11'h000, 0, 0, 11'h000, 32'h0,         0, 0, 1, 0, 11'h000, 32'h0,         0, 0, 32'h0};
        vecs[1]  = '{0, 1, 11'h005, 0, 0, 11'h000, 32'h0,         1, 0, 0, 0, 11'h005, 32'h0,         0, 0, 32'h0};
        vecs[2]  = '{0, 0, 11'h000, 0, 0, 11'h000, 32'h0,         0, 0, 1, 0, 11'h005, 32'h0,         1, 0, 32'hDEADBEEF};
        vecs[3]  = '{0, 0, 11'h000, 1, 1, 11'h7FF, 32'h12345678,  0, 1, 0, 1, 11'h7FF, 32'h12345678,  0, 0, 32'h0};
        vecs[4]  = '{0, 0, 11'h000, 1, 0, 11'h7FF, 32'hAAAA5555,  0, 1, 0, 0, 11'h7FF, 32'hAAAA5555,  0, 0, 32'h0};
        vecs[5]  = '{0, 0, 11'h000, 0, 0, 11'h000, 32'h0,         0, 0, 1, 0, 11'h7FF, 32'hAAAA5555,  0, 1, 32'h12345678};
        vecs[6]  = '{0, 1, 11'h001, 0, 0, 11'h000, 32'h0,         1, 0, 0, 0, 11'h001, 32'h0,         0, 0, 32'h0};
        vecs[7]  = '{0, 0, 11'h000, 1, 0, 11'h002, 32'h0,         0, 1, 0, 0, 11'h002, 32'h0,         1, 0, 32'h11111111};
        vecs[8]  = '{0, 1, 11'h001, 0, 0, 11'h000, 32'h0,         1, 0, 0, 0, 11'h001, 32'h0,         0, 1, 32'h22222222};
        vecs[9]  = '{0, 0, 11'h000, 1, 0, 11'h002, 32'h0,         0, 1, 0, 0, 11'h002, 32'h0,         1, 0, 32'h11111111};
        vecs[10] = '{0, 0, 11'h000, 0, 0, 11'h000, 32'h0,         0, 0, 1, 0, 11'h002, 32'h0,         0, 1, 32'h22222222};
        vecs[11] = '{1, 1, 11'h005, 0, 0, 11'h000, 32'h0,         0, 0, 1, 0, 11'h002, 32'h0,         0, 0, 32'h0};
        vecs[12] = '{1, 1, 11'h005, 1, 0, 11'h003, 32'h0,         0, 1, 0, 0, 11'h003, 32'h0,         0, 0, 32'h0};
        vecs[13] = '{0, 0, 11'h000, 0, 0, 11'h000, 32'h0,         0, 0, 1, 0, 11'h003, 32'h0,         0, 1, 32'h33333333};

        rst_n = 1'b0;
        dbg_halt = 0; fetch_req = 0; fetch_addr = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset fetch_gnt", 32'(fetch_gnt), 32'h0);
        chk("reset dbg_gnt", 32'(dbg_gnt), 32'h0);
        chk("reset mem_hold", 32'(mem_hold), 32'h1);
        chk("reset mem_wr", 32'(mem_wr), 32'h0);
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        chk("reset mem_din", mem_din, 32'h0);
        chk("reset fetch_rvalid", 32'(fetch_rvalid), 32'h0);
        chk("reset dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: single fetch, debug write/read-back, mixed traffic, halt
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].halt, vecs[i].freq, vecs[i].faddr, vecs[i].dreq,
                  vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata);
            chk($sformatf("v%0d fetch_gnt", i), 32'(fetch_gnt), 32'(vecs[i].e_fgnt));
            chk($sformatf("v%0d dbg_gnt", i), 32'(dbg_gnt), 32'(vecs[i].e_dgnt));
            chk($sformatf("v%0d mem_hold", i), 32'(mem_hold), 32'(vecs[i].e_hold));
            chk($sformatf("v%0d mem_wr", i), 32'(mem_wr), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d mem_din", i), mem_din, vecs[i].e_din);
            chk($sformatf("v%0d fetch_rvalid", i), 32'(fetch_rvalid), 32'(vecs[i].e_frv));
            chk($sformatf("v%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].e_drv));
            if (vecs[i].e_frv) chk($sformatf("v%0d fetch_rdata", i), fetch_rdata, vecs[i].e_rdata);
            if (vecs[i].e_drv) chk($sformatf("v%0d dbg_rdata", i), dbg_rdata, vecs[i].e_rdata);
        end

        // Contention: debug wins 8 cycles, fetch forced on the 9th, repeating
        for (int k = 0; k < 27; k++) begin
            logic ef;
            logic pf;
            ef = ((k % 9) == 8);
            pf = (k > 0) && (((k - 1) % 9) == 8);
            drive(0, 1, 11'h001, 1, 0, 11'h002, 32'h0);
            chk($sformatf("starve c%0d fetch_gnt", k), 32'(fetch_gnt), 32'(ef));
            chk($sformatf("starve c%0d dbg_gnt", k), 32'(dbg_gnt), 32'(!ef));
            chk($sformatf("starve c%0d fetch_rvalid", k), 32'(fetch_rvalid), 32'(pf));
            chk($sformatf("starve c%0d dbg_rvalid", k), 32'(dbg_rvalid), 32'((k > 0) && !pf));
            if (pf) chk($sformatf("starve c%0d fetch_rdata", k), fetch_rdata, 32'h1111_1111);
            if ((k > 0) && !pf) chk($sformatf("starve c%0d dbg_rdata", k), dbg_rdata, 32'h2222_2222);
        end
        drive(0, 0, 11'h000, 0, 0, 11'h000, 32'h0);
        chk("starve tail fetch_rvalid", 32'(fetch_rvalid), 32'h1);
        chk("starve tail fetch_rdata", fetch_rdata, 32'h1111_1111);
        chk("starve tail dbg_rvalid", 32'(dbg_rvalid), 32'h0);

        // Halt rises the cycle after a fetch accept; that read still returns
        drive(0, 1, 11'h005, 0, 0, 11'h000, 32'h0);
        chk("pre-halt fetch_gnt", 32'(fetch_gnt), 32'h1);
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 11'h005, 0, 0, 11'h000, 32'h0);
            chk($sformatf("halt c%0d fetch_gnt", k), 32'(fetch_gnt), 32'h0);
            chk($sformatf("halt c%0d mem_hold", k), 32'(mem_hold), 32'h1);
            chk($sformatf("halt c%0d fetch_rvalid", k), 32'(fetch_rvalid), 32'(k == 0));
            if (k == 0) chk("halt c0 fetch_rdata", fetch_rdata, 32'hDEAD_BEEF);
        end

        // Reset asserted the cycle after a fetch accept drops the read
        drive(0, 1, 11'h010, 0, 0, 11'h000, 32'h0);
        chk("rstmid accept fetch_gnt", 32'(fetch_gnt), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid fetch_gnt", 32'(fetch_gnt), 32'h0);
        chk("rstmid dbg_gnt", 32'(dbg_gnt), 32'h0);
        chk("rstmid mem_hold", 32'(mem_hold), 32'h1);
        chk("rstmid fetch_rvalid", 32'(fetch_rvalid), 32'h0);
        @(negedge clk);
        fetch_req = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 11'h000, 0, 0, 11'h000, 32'h0);
            chk($sformatf("post-rst c%0d fetch_rvalid", k), 32'(fetch_rvalid), 32'h0);
            chk($sformatf("post-rst c%0d mem_hold", k), 32'(mem_hold), 32'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_imem_port_arbiter

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Sits in front of the 2048x32 program memory. Shares its single read/write port between the CPU fetch unit and the debug unit.
- Fetch is read-only. Debug reads and writes, e.g. program load or memory inspection.
- Each requester uses a valid/ready handshake. The block drives the memory's address, data-in, write and clock-gate (enable_half) controls.
- It returns read data with a per-requester valid strobe.

Parameters:
- ADDR_W, 11, word address width (2048 words).
- DATA_W, 32, data word width.
- STARVE_MAX, 8, consecutive cycles fetch may lose to debug before it is forced a grant; range 1..255.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- dbg_halt  in  1  1 = CPU halted; fetch is never granted.
- fetch_req  in  1  fetch read request.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_gnt  out  1  fetch request accepted this cycle.
- fetch_rdata  out  DATA_W  fetch read data.
- fetch_rvalid  out  1  fetch_rdata valid.
- dbg_req  in  1  debug request.
- dbg_we  in  1  1 = write, 0 = read; qualified by dbg_req.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  debug request accepted this cycle.
- dbg_rdata  out  DATA_W  debug read data.
- dbg_rvalid  out  1  dbg_rdata valid (reads only).
- mem_addr  out  ADDR_W  to memory address.
- mem_din  out  DATA_W  to memory Datain1.
- mem_wr  out  1  to memory Wr; 1 = write cycle.
- mem_hold  out  1  to memory enable_half; 1 = memory clock gated, no access.
- mem_dout  in  DATA_W  from memory Dataout.

Behaviour:
- Reset (async, Rst_n=0):
  - fetch_rvalid=0, dbg_rvalid=0; starve counter=0; pending-read owner=NONE.
  - fetch_gnt=0, dbg_gnt=0, mem_wr=0, mem_hold=1, mem_addr=0, mem_din=0.
  - Reset asserted mid-read drops that read; no rvalid is produced after reset release.
- Arbitration (combinational, per cycle):
  - At most one grant per cycle.
  - dbg_halt=1: fetch is ineligible.
  - Debug has priority over fetch.
  - Exception: when starve counter == STARVE_MAX and fetch_req=1 and dbg_halt=0, fetch wins.
- Handshake:
  - A request is accepted when req and gnt are both 1 in the same cycle.
  - Requesters must hold addr, we and wdata stable while req=1 and gnt=0.
  - A request may be withdrawn before it is granted.
- Memory drive:
  - Granted cycle: mem_hold=0, mem_addr is the granted address, mem_wr=dbg_we if debug granted, else 0; mem_din=dbg_wdata.
  - No grant: mem_hold=1, mem_wr=0, and mem_addr/mem_din hold their last value.
- Read latency:
  - Read accepted in cycle N: the owner's rvalid=1 in cycle N+1 and rdata=mem_dout sampled in N+1.
  - The owner is stored in a 1-deep pending register.
  - rdata outputs are muxed from mem_dout; they are valid only when the matching rvalid=1.
  - Back-to-back reads every cycle are allowed: throughput 1/cycle.
- Writes:
  - Complete in the accept cycle; no rvalid.
  - A read of the same address accepted the next cycle returns the new data.
- Starve counter (saturating, 0..STARVE_MAX):
  - Increments when fetch_req=1, dbg_halt=0 and debug wins.
  - Clears on a fetch grant, when fetch_req=0, or when dbg_halt=1.
- Pending read and dbg_halt: a fetch read accepted before dbg_halt rises still delivers its fetch_rvalid.
- Address range: addresses use the full ADDR_W range; no bounds check.
- Internal FSM states (owner register): IDLE, FETCH_RD, DBG_RD, DBG_WR. The next state is derived from the grant every cycle. DBG_WR produces no output strobe.

Decomposition:
- Package imem_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - typedef enum owner_e {OWN_NONE, OWN_FETCH, OWN_DBG}.
  - typedef enum state_e {IDLE, FETCH_RD, DBG_RD, DBG_WR}.
- One sub-module: imem_arb_starve_cnt (saturating counter, parameter STARVE_MAX). It takes inc and clr and outputs at_max.

Test Plan:
- Reset mid-read: fetch read of 0x010 accepted, then Rst_n=0 the next cycle -> fetch_rvalid never asserts, mem_hold=1, all grants 0.
- Single fetch: fetch_req, addr=0x005, memory preloaded 0xDEADBEEF -> fetch_gnt in cycle N, fetch_rvalid=1 and fetch_rdata=0xDEADBEEF in N+1, mem_wr=0 throughout.
- Debug write then read:
  - Write 0x7FF <- 0x12345678 -> dbg_gnt=1 and mem_wr=1 in that cycle, dbg_rvalid stays 0.
  - Read 0x7FF the next cycle -> dbg_rvalid=1, dbg_rdata=0x12345678.
- Contention and starvation (STARVE_MAX=8): fetch_req and dbg_req both held high continuously -> debug granted 8 cycles, fetch granted on cycle 9, debug again from cycle 10. Pattern repeats every 9 cycles.
- Halt: dbg_halt=1 with fetch_req=1 for 20 cycles and no debug request -> fetch_gnt stays 0, mem_hold=1. A fetch read accepted the cycle before halt rose still returns fetch_rvalid.
- Back-to-back mixed traffic: alternating grants fetch/debug reads on 0x001/0x002 every cycle -> each rvalid appears exactly one cycle after its grant, with the correct owner and no cross-delivery.
